// File: rtl/ahb_slave_ctrl.sv
// ahb_slave_ctrl
// AHB-Lite slave control stage. It registers the address phase (HADDR, HWRITE,
// HSIZE) into the data phase. It drives the size-control stage
// (size_enable/size_hsize) and issues one write request to the write buffer or
// one read request to the read port per data phase. It inserts HREADYOUT wait
// states and produces the two-cycle ERROR response for illegal sizes and
// misaligned addresses.
//
// Ports
//   HCLK, HRESET          bus clock, asynchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HREADY AHB address-phase inputs
//   HREADYOUT, HRESP      slave ready / response (0 OKAY, 1 ERROR)
//   HRDATA                read data, pass-through of rd_data
//   size_enable,
//   size_hsize            enable and registered size to the size-control stage
//   size_error            illegal-size flag returned by the size-control stage
//   wr_valid, wr_addr,
//   buf_ready             write request handshake with the write buffer
//   rd_req, rd_addr,
//   rd_data, rd_valid     read request handshake with the read port
module ahb_slave_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [127:0]      HRDATA,
    output logic              size_enable,
    output logic [2:0]        size_hsize,
    input  logic              size_error,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              buf_ready,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [127:0]      rd_data,
    input  logic              rd_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DATA = 2'b01,
        ST_ERR  = 2'b10
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [2:0]        r_size;
    logic              w_acc;
    logic              w_misalign;
    logic              w_err;
    logic              w_done;

    // Low-address-bit mask that must be zero for a transfer of the given size.
    function automatic logic [3:0] size_mask(input logic [2:0] sz);
        logic [3:0] m;
        case (sz)
            3'd0:    m = 4'h0;
            3'd1:    m = 4'h1;
            3'd2:    m = 4'h3;
            3'd3:    m = 4'h7;
            3'd4:    m = 4'hF;
            default: m = 4'h0;
        endcase
        return m;
    endfunction

    assign w_acc      = HSEL & HTRANS[1] & HREADY;
    // Sizes above 4 are flagged by the size-control stage, so only the
    // alignment of legal sizes is checked here.
    assign w_misalign = (r_size <= 3'd4) && ((r_addr[3:0] & size_mask(r_size)) != 4'd0);
    assign w_err      = size_error | w_misalign;

    assign size_hsize = r_size;
    assign wr_addr    = r_addr;
    assign rd_addr    = r_addr;
    assign HRDATA     = rd_data;

    // State register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Address-phase capture; loads only when a transfer is accepted.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
        end else if (w_acc) begin
            r_addr  <= HADDR;
            r_write <= HWRITE;
            r_size  <= HSIZE;
        end
    end

    // Next-state and data-phase outputs.
    always_comb begin
        w_next      = ST_IDLE;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        size_enable = 1'b0;
        wr_valid    = 1'b0;
        rd_req      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_next = w_acc ? ST_DATA : ST_IDLE;
            end
            ST_DATA: begin
                // Enabled for reads too so size_error is valid for every transfer.
                size_enable = 1'b1;
                if (w_err) begin
                    HREADYOUT = 1'b0;
                    HRESP     = 1'b1;
                    w_next    = ST_ERR;
                end else begin
                    if (r_write) begin
                        wr_valid = 1'b1;
                        w_done   = buf_ready;
                    end else begin
                        rd_req = 1'b1;
                        w_done = rd_valid;
                    end
                    HREADYOUT = w_done;
                    if (!w_done) begin
                        w_next = ST_DATA;
                    end else begin
                        w_next = w_acc ? ST_DATA : ST_IDLE;
                    end
                end
            end
            ST_ERR: begin
                HRESP  = 1'b1;
                w_next = w_acc ? ST_DATA : ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
